// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the hazard detection unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1
    } hdu_state_t;

    localparam logic [4:0] REG_X0         = 5'd0;
    localparam int         MAX_LOAD_STALL = 3;
    localparam int         REMAIN_W       = 2;

    // True when an enabled source register names the given destination.
    function automatic logic regMatch(input logic used, input logic [4:0] src,
                                      input logic [4:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use / redirect / memory-busy hazard control for a 5-stage RISC-V pipeline.
// All control outputs are combinational from inputs and the stall FSM.
module hazard_detect_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             hazard_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             busy_o
);

    // Out-of-range depths are clamped into 1..MAX_LOAD_STALL.
    localparam int STALL_DEPTH = (LOAD_STALL_CYCLES < 1) ? 1 :
                                 (LOAD_STALL_CYCLES > MAX_LOAD_STALL) ? MAX_LOAD_STALL :
                                 LOAD_STALL_CYCLES;
    localparam logic [REMAIN_W-1:0] STALL_RELOAD = REMAIN_W'(STALL_DEPTH - 1);
    localparam logic                MULTI_STALL  = (STALL_DEPTH > 1);

    hdu_state_t          state;
    logic [REMAIN_W-1:0] remaining;
    logic                luHit;

    always_comb begin
        luHit = ex_memread_i && (ex_rd_i != REG_X0) &&
                (regMatch(id_rs1_used_i, id_rs1_i, ex_rd_i) ||
                 regMatch(id_rs2_used_i, id_rs2_i, ex_rd_i));
    end

    // Priority: reset > memory busy > redirect > load-use stall > normal flow.
    always_comb begin
        hazard_o     = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        freeze_o     = 1'b0;
        if (rst_i) begin
            hazard_o     = 1'b1;
            ifid_flush_o = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (mem_busy_i) begin
            freeze_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (ex_redirect_i) begin
            hazard_o     = 1'b1;
            ifid_flush_o = 1'b1;
        end else if ((state == LSTALL) || luHit) begin
            hazard_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end
    end

    assign busy_o = !rst_i && (state != RUN);

    // A frozen cycle holds both state and remaining so the bubble count is preserved.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            remaining <= '0;
        end else if (mem_busy_i) begin
            state     <= state;
            remaining <= remaining;
        end else if (ex_redirect_i) begin
            state     <= RUN;
            remaining <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (luHit && MULTI_STALL) begin
                        state     <= LSTALL;
                        remaining <= STALL_RELOAD;
                    end
                end
                LSTALL: begin
                    if (remaining <= REMAIN_W'(1)) begin
                        state     <= RUN;
                        remaining <= '0;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    remaining <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (!pc_write_o),
        .count_o(stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Drives three configurations (default, 3-deep stall, 4-bit counter) with shared
// stimulus and compares each against a pending-bubble reference model.
module tb_hazard_detect_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       rs1Used = 1'b0, rs2Used = 1'b0, memRead = 1'b0, redirect = 1'b0, memBusy = 1'b0;

    logic        hazA, pcA, ifidA, flushA, frzA, busyA;
    logic        hazB, pcB, ifidB, flushB, frzB, busyB;
    logic        hazC, pcC, ifidC, flushC, frzC, busyC;
    logic [15:0] cntA, cntB;
    logic [3:0]  cntC;

    logic [5:0]  obsCtl[3], expCtl[3];
    logic [15:0] obsCnt[3], expCnt[3];

    int pend[3];
    int cnt[3];
    int lsc[3]  = '{1, 3, 1};
    int cmax[3] = '{65535, 65535, 15};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_detect_unit dutA (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1Used), .id_rs2_used_i(rs2Used), .ex_rd_i(rd),
        .ex_memread_i(memRead), .ex_redirect_i(redirect), .mem_busy_i(memBusy),
        .hazard_o(hazA), .pc_write_o(pcA), .ifid_write_o(ifidA), .ifid_flush_o(flushA),
        .freeze_o(frzA), .stall_cnt_o(cntA), .busy_o(busyA));

    hazard_detect_unit #(.LOAD_STALL_CYCLES(3)) dutB (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1Used), .id_rs2_used_i(rs2Used), .ex_rd_i(rd),
        .ex_memread_i(memRead), .ex_redirect_i(redirect), .mem_busy_i(memBusy),
        .hazard_o(hazB), .pc_write_o(pcB), .ifid_write_o(ifidB), .ifid_flush_o(flushB),
        .freeze_o(frzB), .stall_cnt_o(cntB), .busy_o(busyB));

    hazard_detect_unit #(.CNT_W(4)) dutC (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1Used), .id_rs2_used_i(rs2Used), .ex_rd_i(rd),
        .ex_memread_i(memRead), .ex_redirect_i(redirect), .mem_busy_i(memBusy),
        .hazard_o(hazC), .pc_write_o(pcC), .ifid_write_o(ifidC), .ifid_flush_o(flushC),
        .freeze_o(frzC), .stall_cnt_o(cntC), .busy_o(busyC));

    // Control vector layout: {hazard, pc_write, ifid_write, ifid_flush, freeze, busy}
    assign obsCtl[0] = {hazA, pcA, ifidA, flushA, frzA, busyA};
    assign obsCtl[1] = {hazB, pcB, ifidB, flushB, frzB, busyB};
    assign obsCtl[2] = {hazC, pcC, ifidC, flushC, frzC, busyC};
    assign obsCnt[0] = cntA;
    assign obsCnt[1] = cntB;
    assign obsCnt[2] = {12'd0, cntC};

    // Drives one cycle, predicts this cycle's outputs, then advances the model past the edge.
    task automatic apply(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2, input logic [4:0] d,
                         input logic mr, input logic rdr, input logic mb);
        logic hit;
        logic stall;
        @(posedge clk);
        #1;
        rst = r; rs1 = s1; rs2 = s2; rs1Used = u1; rs2Used = u2;
        rd = d; memRead = mr; redirect = rdr; memBusy = mb;
        hit = mr && (d != 5'd0) && ((u1 && s1 == d) || (u2 && s2 == d));
        for (int k = 0; k < 3; k++) begin
            if (r)              expCtl[k] = 6'b100100;
            else if (mb)        expCtl[k] = {5'b00001, pend[k] > 0};
            else if (rdr)       expCtl[k] = {5'b11110, pend[k] > 0};
            else if (pend[k] > 0) expCtl[k] = 6'b100001;
            else if (hit)       expCtl[k] = 6'b100000;
            else                expCtl[k] = 6'b011000;
            expCnt[k] = 16'(cnt[k]);
            stall = !expCtl[k][4];
            if (r) begin
                pend[k] = 0;
                cnt[k]  = 0;
            end else begin
                if (stall && cnt[k] < cmax[k]) cnt[k]++;
                if (mb) ;
                else if (rdr)          pend[k] = 0;
                else if (pend[k] > 0)  pend[k]--;
                else if (hit)          pend[k] = lsc[k] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) apply(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
            else       idle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL reset dut%0d t=%0t ctl=%b want %b cnt=%0d want %0d",
                             k, $time, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: apply(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
                4: apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
                default: idle();
            endcase
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL load_use dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    task automatic test_multi_stall();
        for (int c = 0; c < 12; c++) begin
            case (c)
                0, 6: apply(1'b0, 5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
                7:    apply(1'b0, 5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
                default: idle();
            endcase
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL multi_stall dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: apply(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
                3: apply(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
                4: apply(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
                default: idle();
            endcase
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL redirect dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    task automatic test_mem_busy();
        for (int c = 0; c < 7; c++) begin
            if (c < 4)       apply(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
            else if (c == 4) apply(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
            else             idle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL mem_busy dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 21; c++) begin
            apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL saturation dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
        idle();
        checks++;
        if (cntC !== 4'd15) begin
            errors++;
            $display("FAIL saturation_stick got %0d want 15", cntC);
        end
        checks++;
        if (cntA !== 16'd21) begin
            errors++;
            $display("FAIL saturation_wide got %0d want 21", cntA);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 49) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obsCtl[k] !== expCtl[k] || obsCnt[k] !== expCnt[k]) begin
                    errors++;
                    $display("FAIL random dut%0d c=%0d ctl=%b want %b cnt=%0d want %0d",
                             k, c, obsCtl[k], expCtl[k], obsCnt[k], expCnt[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            pend[k] = 0;
            cnt[k]  = 0;
        end
        // Settle every register before the first checked cycle.
        apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_multi_stall();
        test_redirect();
        test_mem_busy();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
